mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Memory-side responder for the MEM stage of the pipeline. It accepts one load or store request at a time and serialises it onto the 8-bit byte-wide RAM port. Loads are assembled little-endian and sign- or zero-extended before return; completion is signalled with a one-cycle done pulse. It sits between the MEM stage (initiator) and the external RAM.

Parameters:
ADDR_WIDTH, 32, width of request and RAM addresses; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low
rdy  in  1  global ready; low freezes all state
req_valid_i  in  1  request strobe, sampled only in IDLE
req_we_i  in  1  1=store, 0=load
req_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed_i  in  1  load sign-extend enable (ignored for word/store)
req_addr_i  in  ADDR_WIDTH  byte address of first byte
req_wdata_i  in  32  store data, low bytes used
busy_o  out  1  high in every non-IDLE state
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  load result, valid while done_o=1
ram_a_o  out  ADDR_WIDTH  RAM byte address
ram_wr_o  out  1  RAM write enable
ram_dout_o  out  8  RAM write byte
ram_din_i  in  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all outputs 0; byte counter 0; any in-flight access abandoned, no done_o. Applies mid-operation.
- N = 1/2/4 bytes for width 00/01/(10,11).
- States: IDLE, READ, WRITE, DONE.
- IDLE: outputs 0. At an edge with rdy=1, req_valid_i=1: latch addr/width/signed/wdata, clear counter, go READ (we=0) or WRITE (we=1). Cycle after acceptance = cycle 1.
- WRITE: cycle i (1..N): ram_a_o=addr+(i-1), ram_wr_o=1, ram_dout_o=wdata byte (i-1) (little-endian). After byte N -> DONE. done_o high in cycle N+1.
- READ: cycles 1..N present ram_a_o=addr+(i-1), ram_wr_o=0. Byte for cycle-k address captured at end of cycle k+1 into rdata byte k-1. Cycle N+1: ram_a_o held at last address, capture last byte. -> DONE; done_o high in cycle N+2.
- DONE: done_o=1, busy_o=1, rdata_o final value; ram_wr_o=0, ram_a_o=0; next edge -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Extension: byte signed -> bits[31:8]=bit7; half signed -> bits[31:16]=bit15; unsigned -> zero. Word: none. Stores leave rdata_o=0.
- rdy=0: state, counter, latched fields, rdata frozen; ram_wr_o forced 0 in those cycles (no duplicate/extra writes); done_o forced 0 and re-asserted once rdy returns. RAM side is also paused while rdy=0 (ram_din_i holds).
- req_valid_i while busy_o=1 ignored, not queued.
- Address increment wraps (0xFFFFFFFF+1=0).
- Exactly N RAM writes per store; no RAM write ever outside WRITE.

Test Plan:
- Word load addr 0x1000, RAM bytes 78,56,34,12 -> ram_a_o 0x1000..0x1003 in cycles 1-4, done_o only in cycle 6, rdata_o=0x12345678, ram_wr_o never 1.
- Signed byte load of 0x80 -> rdata_o=0xFFFFFF80, done cycle 3; unsigned half load of 0x80,0xFF -> 0x0000FF80, done cycle 4.
- Word store 0xDEADBEEF at 0x20 -> ram_wr_o=1 cycles 1-4, addresses 0x20-0x23, data EF,BE,AD,DE; done cycle 5; rdata_o=0.
- Same store with rdy=0 in cycles 2-3 -> exactly 4 writes with correct bytes, none while rdy=0, done cycle 7; second req_valid_i during busy ignored.
- Half store 0xA55A at 0xFFFFFFFF -> writes 5A@0xFFFFFFFF, A5@0x00000000.
- rst=0 in cycle 2 of a word load -> next cycle all outputs 0, no done_o; fresh request after release completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Serialises one load/store request onto a byte-wide RAM port.
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_width_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [2:0]            cnt_q,    cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [1:0]            width_q,  width_d;
    logic                  signed_q, signed_d;
    logic [31:0]           wdata_q,  wdata_d;
    logic [31:0]           rdata_q,  rdata_d;

    logic [2:0]            last_idx;
    logic [1:0]            cap_idx;
    logic [2:0]            rd_off;
    logic [31:0]           ext;

    always_comb begin
        case (width_q)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    // Read data lags its address by one cycle, so cycle k stores byte k-2.
    assign cap_idx = cnt_q[1:0] - 2'd1;
    // The extra capture cycle keeps presenting the final address.
    assign rd_off  = (cnt_q > last_idx) ? last_idx : cnt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        width_d  = width_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_d   = req_addr_i;
                        width_d  = req_width_i;
                        signed_d = req_signed_i;
                        wdata_d  = req_wdata_i;
                        rdata_d  = 32'h0;
                        cnt_d    = 3'd0;
                        state_d  = req_we_i ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_READ: begin
                    if (cnt_q != 3'd0) begin
                        rdata_d[{cap_idx, 3'b000} +: 8] = ram_din_i;
                    end
                    if (cnt_q == last_idx + 3'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            width_q  <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        ram_a_o    = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'h00;
        case (state_q)
            S_WRITE: begin
                ram_a_o    = addr_q + ADDR_WIDTH'(cnt_q);
                ram_wr_o   = rdy;
                ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            end
            S_READ: begin
                ram_a_o = addr_q + ADDR_WIDTH'(rd_off);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (width_q)
            2'b00:   ext = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
            2'b01:   ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
            default: ext = rdata_q;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE) && rdy;
    assign rdata_o = (state_q == S_DONE) ? ext : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Scenario and randomized checks of mem_ctrl against a byte-RAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        req_valid_i;
    logic        req_we_i;
    logic [1:0]  req_width_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i = 8'h00;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .req_valid_i  (req_valid_i),
        .req_we_i     (req_we_i),
        .req_width_i  (req_width_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .ram_a_o      (ram_a_o),
        .ram_wr_o     (ram_wr_o),
        .ram_dout_o   (ram_dout_o),
        .ram_din_i    (ram_din_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Byte-wide synchronous RAM; it pauses together with the controller.
    always @(posedge clk) begin
        if (rdy) ram_din_i <= mem_rd(ram_a_o);
        if (ram_wr_o) begin
            mem[ram_a_o] = ram_dout_o;
            wlog_a.push_back(ram_a_o);
            wlog_d.push_back(ram_dout_o);
        end
    end

    // One full transaction: stall_mask bit c drops rdy in cycle c after acceptance.
    task automatic run_op(input string name, input logic we, input logic [1:0] width,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [63:0] stall_mask, input bit inject);
        int          n, base, act, p;
        logic [31:0] exp_r, exp_a;
        logic [31:0] ea [$];
        logic [7:0]  ed [$];
        logic        exp_done, done_seen;
        n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
        base = we ? n + 1 : n + 2;
        exp_r = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (we) begin
                ea.push_back(addr + 32'(i));
                ed.push_back(8'((wdata >> (8 * i)) & 32'hFF));
            end else begin
                exp_r = exp_r | (32'(mem_rd(addr + 32'(i))) << (8 * i));
            end
        end
        if (!we && sgn && n == 1 && exp_r[7])  exp_r = exp_r | 32'hFFFF_FF00;
        if (!we && sgn && n == 2 && exp_r[15]) exp_r = exp_r | 32'hFFFF_0000;

        @(negedge clk);
        wlog_a.delete();
        wlog_d.delete();
        rdy = 1'b1;
        req_valid_i = 1'b1; req_we_i = we; req_width_i = width;
        req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wdata;

        act = 0;
        done_seen = 1'b0;
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            @(negedge clk);
            req_valid_i = inject && (c == 2);
            if (inject && c == 2) begin
                req_we_i = 1'b1; req_addr_i = 32'h5555_0000; req_width_i = 2'b10;
            end
            rdy = !stall_mask[c];
            #1;
            exp_done = rdy && (act == base - 1);
            checks++;
            if (done_o !== exp_done) begin
                failures++;
                $display("FAIL %s done c%0d: got %b want %b", name, c, done_o, exp_done);
            end
            checks++;
            if (busy_o !== 1'b1) begin
                failures++;
                $display("FAIL %s busy c%0d: got %b want 1", name, c, busy_o);
            end
            if (act < base - 1) begin
                p = act;
                if (we) exp_a = addr + 32'(p);
                else    exp_a = addr + 32'((p > n - 1) ? n - 1 : p);
                checks++;
                if (ram_a_o !== exp_a || ram_wr_o !== (we && rdy)) begin
                    failures++;
                    $display("FAIL %s ram c%0d: got a=%h wr=%b want a=%h wr=%b",
                             name, c, ram_a_o, ram_wr_o, exp_a, we && rdy);
                end
                if (we && rdy) begin
                    checks++;
                    if (ram_dout_o !== ed[p]) begin
                        failures++;
                        $display("FAIL %s dout c%0d: got %h want %h", name, c, ram_dout_o, ed[p]);
                    end
                end
            end else begin
                checks++;
                if (rdata_o !== exp_r || ram_wr_o !== 1'b0 || ram_a_o !== 32'h0) begin
                    failures++;
                    $display("FAIL %s result: got rdata=%h wr=%b a=%h want rdata=%h wr=0 a=0",
                             name, rdata_o, ram_wr_o, ram_a_o, exp_r);
                end
            end
            if (exp_done) done_seen = 1'b1;
            if (rdy) act++;
        end
        if (!done_seen) begin
            failures++;
            $display("FAIL %s timeout: got no done want done", name);
        end

        @(negedge clk);
        req_valid_i = 1'b0;
        rdy = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ram_wr_o !== 1'b0 || rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL %s idle: got busy=%b done=%b wr=%b rdata=%h want all 0",
                     name, busy_o, done_o, ram_wr_o, rdata_o);
        end
        checks++;
        if (wlog_a.size() != ea.size()) begin
            failures++;
            $display("FAIL %s write count: got %0d want %0d", name, wlog_a.size(), ea.size());
        end else begin
            for (int i = 0; i < ea.size(); i++) begin
                checks++;
                if (wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL %s write %0d: got %h@%h want %h@%h",
                             name, i, wlog_d[i], wlog_a[i], ed[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_width_i = 2'b00; req_signed_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rdata_o !== 32'h0 ||
            ram_a_o !== 32'h0 || ram_wr_o !== 1'b0 || ram_dout_o !== 8'h00) begin
            failures++;
            $display("FAIL reset: got busy=%b done=%b rdata=%h a=%h wr=%b dout=%h want all 0",
                     busy_o, done_o, rdata_o, ram_a_o, ram_wr_o, ram_dout_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_loads();
        mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56;
        mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
        run_op("word_load", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 64'h0, 1'b0);
        mem[32'h2000] = 8'h80;
        run_op("sbyte_load", 1'b0, 2'b00, 1'b1, 32'h2000, 32'h0, 64'h0, 1'b0);
        mem[32'h3000] = 8'h80; mem[32'h3001] = 8'hFF;
        run_op("uhalf_load", 1'b0, 2'b01, 1'b0, 32'h3000, 32'h0, 64'h0, 1'b0);
        run_op("shalf_load", 1'b0, 2'b01, 1'b1, 32'h3000, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic test_stores();
        run_op("word_store", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 64'h0, 1'b0);
        run_op("stall_store", 1'b1, 2'b11, 1'b0, 32'h20, 32'hDEAD_BEEF, 64'h0C, 1'b1);
        run_op("wrap_store", 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_A55A, 64'h0, 1'b0);
        run_op("wrap_load", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        rdy = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_width_i = 2'b10;
        req_signed_i = 1'b0; req_addr_i = 32'h1000;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rdata_o !== 32'h0 ||
            ram_a_o !== 32'h0 || ram_wr_o !== 1'b0 || ram_dout_o !== 8'h00) begin
            failures++;
            $display("FAIL midop_reset: got busy=%b done=%b rdata=%h a=%h wr=%b want all 0",
                     busy_o, done_o, rdata_o, ram_a_o, ram_wr_o);
        end
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL midop_quiet c%0d: got done=%b busy=%b want 0 0", c, done_o, busy_o);
            end
        end
        run_op("after_reset", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] mask;
        logic [31:0] addr;
        for (int k = 0; k < 40; k++) begin
            mask = 64'h0;
            for (int b = 1; b <= 12; b++) mask[b] = ($urandom % 4 == 0);
            addr = ($urandom % 3 == 0) ? 32'hFFFF_FFFC + ($urandom % 4) : $urandom;
            run_op("random", 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
                   mask, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
